// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - LIF neuron array default constants and saturating add helper
package lif_pkg;

    localparam int LIF_N_NEURONS  = 2;
    localparam int LIF_IN_W       = 8;
    localparam int LIF_STATE_W    = 8;
    localparam int LIF_LEAK_SHIFT = 1;
    localparam int LIF_REFRAC     = 2;

    // Unsigned add clamped to 2^width-1; the 33-bit intermediate keeps the carry.
    function automatic logic [31:0] lif_sat_add(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - one leaky integrate-and-fire neuron (state, refractory counter, spike reg)
// Build option: LIF_SOFT_RESET_EN keeps the above-threshold residual on a spike.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int IN_W       = LIF_IN_W,
    parameter int STATE_W    = LIF_STATE_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int REFRAC     = LIF_REFRAC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [IN_W-1:0]    current,
    input  logic [STATE_W-1:0] threshold,
    output logic               spike,
    output logic [STATE_W-1:0] state_next
);

    localparam int CNT_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               spike_d;
    logic [STATE_W-1:0] leaked;
    logic [31:0]        sat_sum;
    logic               fire;

    assign leaked  = state_q - (state_q >> LEAK_SHIFT);
    assign sat_sum = lif_sat_add(32'(leaked), 32'(current), STATE_W);
    assign fire    = (threshold != '0) && (sat_sum >= 32'(threshold));

    always_comb begin
        state_next = state_q;
        cnt_d      = cnt_q;
        spike_d    = spike;
        if (ena) begin
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - CNT_W'(1);
                spike_d = 1'b0;
            end else if (fire) begin
                spike_d = 1'b1;
                cnt_d   = CNT_W'(REFRAC);
`ifdef LIF_SOFT_RESET_EN
                state_next = sat_sum[STATE_W-1:0] - threshold;
`else
                state_next = '0;
`endif
            end else begin
                spike_d    = 1'b0;
                state_next = sat_sum[STATE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            cnt_q   <= '0;
            spike   <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_d;
            spike   <= spike_d;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - array of N LIF neurons with shared threshold and selectable state readout
// Build option: LIF_SOFT_RESET_EN selects residual-keeping reset in every neuron.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int  N_NEURONS  = LIF_N_NEURONS,
    parameter int  IN_W       = LIF_IN_W,
    parameter int  STATE_W    = LIF_STATE_W,
    parameter int  LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int  REFRAC     = LIF_REFRAC,
    localparam int SEL_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [N_NEURONS*IN_W-1:0] current,
    input  logic [STATE_W-1:0]        threshold,
    input  logic [SEL_W-1:0]          state_sel,
    output logic [N_NEURONS-1:0]      spike_out,
    output logic [STATE_W-1:0]        state_out
);

    logic [STATE_W-1:0] state_next [N_NEURONS];
    logic [STATE_W-1:0] sel_state;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        lif_neuron_core #(
            .IN_W       (IN_W),
            .STATE_W    (STATE_W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_core (
            .clk        (clk),
            .rst        (rst),
            .ena        (ena),
            .current    (current[i*IN_W +: IN_W]),
            .threshold  (threshold),
            .spike      (spike_out[i]),
            .state_next (state_next[i])
        );
    end

    // Readout taps the post-update value so state_out matches the state just written.
    always_comb begin
        sel_state = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (int'(state_sel) == i) sel_state = state_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_out <= '0;
        else     state_out <= sel_state;
    end

endmodule
